// File: rtl/register_map_pkg.sv
// Shared widths, architectural register address map and FSM state type for the
// register read port.
package register_map_pkg;

    localparam int unsigned DATA_WIDTH   = 20;
    localparam int unsigned ADDR_WIDTH   = 5;
    localparam int unsigned STATUS_WIDTH = 15;
    localparam int unsigned NUM_GPR      = 6;
    localparam int unsigned NUM_PTR      = 6;

    localparam logic [ADDR_WIDTH-1:0] ADDR_GPR1        = 5'd0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_GPR2        = 5'd1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_GPR3        = 5'd2;
    localparam logic [ADDR_WIDTH-1:0] ADDR_GPR4        = 5'd3;
    localparam logic [ADDR_WIDTH-1:0] ADDR_GPR5        = 5'd4;
    localparam logic [ADDR_WIDTH-1:0] ADDR_GPR6        = 5'd5;
    localparam logic [ADDR_WIDTH-1:0] ADDR_IS          = 5'd6;
    localparam logic [ADDR_WIDTH-1:0] ADDR_SS          = 5'd7;
    localparam logic [ADDR_WIDTH-1:0] ADDR_DS          = 5'd8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_IP          = 5'd9;
    localparam logic [ADDR_WIDTH-1:0] ADDR_SP          = 5'd10;
    localparam logic [ADDR_WIDTH-1:0] ADDR_DP          = 5'd11;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS      = 5'd12;
    localparam logic [ADDR_WIDTH-1:0] ADDR_INSTR_COUNT = 5'd13;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MEM_ACCESS  = 5'd14;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MEM_CORR    = 5'd15;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST_MAPPED = 5'd15;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StRespond
    } rrp_state_t;

endpackage

// File: rtl/register_read_mux.sv
// Combinational selector: maps one register address to its current value and
// flags addresses outside the architectural map.
module register_read_mux
    import register_map_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [NUM_GPR*DATA_WIDTH-1:0] gpr_flat,
    input  logic [NUM_PTR*DATA_WIDTH-1:0] ptr_flat,
    input  logic [STATUS_WIDTH-1:0]       status_register,
    input  logic [DATA_WIDTH-1:0]         instruction_count,
    input  logic [DATA_WIDTH-1:0]         memory_access_count,
    input  logic [DATA_WIDTH-1:0]         memory_correction_count,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          unmapped
);

    always_comb begin
        data     = '0;
        unmapped = 1'b0;
        case (addr)
            ADDR_GPR1:        data = gpr_flat[0*DATA_WIDTH +: DATA_WIDTH];
            ADDR_GPR2:        data = gpr_flat[1*DATA_WIDTH +: DATA_WIDTH];
            ADDR_GPR3:        data = gpr_flat[2*DATA_WIDTH +: DATA_WIDTH];
            ADDR_GPR4:        data = gpr_flat[3*DATA_WIDTH +: DATA_WIDTH];
            ADDR_GPR5:        data = gpr_flat[4*DATA_WIDTH +: DATA_WIDTH];
            ADDR_GPR6:        data = gpr_flat[5*DATA_WIDTH +: DATA_WIDTH];
            ADDR_IS:          data = ptr_flat[0*DATA_WIDTH +: DATA_WIDTH];
            ADDR_SS:          data = ptr_flat[1*DATA_WIDTH +: DATA_WIDTH];
            ADDR_DS:          data = ptr_flat[2*DATA_WIDTH +: DATA_WIDTH];
            ADDR_IP:          data = ptr_flat[3*DATA_WIDTH +: DATA_WIDTH];
            ADDR_SP:          data = ptr_flat[4*DATA_WIDTH +: DATA_WIDTH];
            ADDR_DP:          data = ptr_flat[5*DATA_WIDTH +: DATA_WIDTH];
            ADDR_STATUS:      data = {{(DATA_WIDTH-STATUS_WIDTH){1'b0}}, status_register};
            ADDR_INSTR_COUNT: data = instruction_count;
            ADDR_MEM_ACCESS:  data = memory_access_count;
            ADDR_MEM_CORR:    data = memory_correction_count;
            default:          unmapped = 1'b1;
        endcase
    end

endmodule

// File: rtl/register_read_port.sv
// Dual-address register read responder: latches a request, snapshots both
// selected registers on the same edge and holds the response until accepted.
module register_read_port
    import register_map_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr_a,
    input  logic [ADDR_WIDTH-1:0]         req_addr_b,
    input  logic [NUM_GPR*DATA_WIDTH-1:0] gpr_flat,
    input  logic [NUM_PTR*DATA_WIDTH-1:0] ptr_flat,
    input  logic [STATUS_WIDTH-1:0]       status_register,
    input  logic [DATA_WIDTH-1:0]         instruction_count,
    input  logic [DATA_WIDTH-1:0]         memory_access_count,
    input  logic [DATA_WIDTH-1:0]         memory_correction_count,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data_a,
    output logic [DATA_WIDTH-1:0]         rsp_data_b,
    output logic                          rsp_error,
    output logic                          same_register_flag
);

    rrp_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;
    logic                    error_q, error_d, same_q, same_d;
    logic [DATA_WIDTH-1:0]   mux_a, mux_b;
    logic                    unmapped_a, unmapped_b;

    register_read_mux u_mux_a (
        .addr                    (addr_a_q),
        .gpr_flat                (gpr_flat),
        .ptr_flat                (ptr_flat),
        .status_register         (status_register),
        .instruction_count       (instruction_count),
        .memory_access_count     (memory_access_count),
        .memory_correction_count (memory_correction_count),
        .data                    (mux_a),
        .unmapped                (unmapped_a)
    );

    register_read_mux u_mux_b (
        .addr                    (addr_b_q),
        .gpr_flat                (gpr_flat),
        .ptr_flat                (ptr_flat),
        .status_register         (status_register),
        .instruction_count       (instruction_count),
        .memory_access_count     (memory_access_count),
        .memory_correction_count (memory_correction_count),
        .data                    (mux_b),
        .unmapped                (unmapped_b)
    );

    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        error_d  = error_q;
        same_d   = same_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_a_d = req_addr_a;
                    addr_b_d = req_addr_b;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                // Both ports load on this one edge so counter pairs stay coherent.
                data_a_d = mux_a;
                data_b_d = mux_b;
                error_d  = unmapped_a | unmapped_b;
                same_d   = (addr_a_q == addr_b_q);
                state_d  = StRespond;
            end
            StRespond: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            error_q  <= 1'b0;
            same_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            error_q  <= error_d;
            same_q   <= same_d;
        end
    end

    assign req_ready          = (state_q == StIdle);
    assign rsp_valid          = (state_q == StRespond);
    assign rsp_data_a         = data_a_q;
    assign rsp_data_b         = data_b_q;
    assign rsp_error          = error_q;
    assign same_register_flag = same_q;

endmodule

// File: doc/register_read_port.md
# register_read_port

Dual-address read responder for the architectural register set: the read-side counterpart to the general-purpose, pointer, status and increment registers. Requests arrive on a valid/ready handshake and carry two 5-bit register addresses. The block captures both selected values in the same cycle, which keeps counter snapshots coherent. It then holds the response on a valid/ready handshake until it is accepted. It sits between the register blocks and the instruction decode / debug readout logic, and reports same-address reads for the status register's `same_register_flag`.

## Interface
- `DATA_WIDTH`, 20, width of every register and response word
- `STATUS_WIDTH`, 15, width of the status register input
- `ADDR_WIDTH`, 5, register address width
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_addr_a`, `req_addr_b`  in  5 each  register addresses
- `gpr_flat`  in  120  GPR1..GPR6, GPR1 in bits [19:0]
- `ptr_flat`  in  120  IS, SS, DS, IP, SP, DP, IS in bits [19:0]
- `status_register`  in  15  packed flag word
- `instruction_count`, `memory_access_count`, `memory_correction_count`  in  20 each  event counters
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_data_a`, `rsp_data_b`  out  20 each  captured values
- `rsp_error`  out  1  at least one address was unmapped
- `same_register_flag`  out  1  `addr_a == addr_b` for the current response

## Operation
- Address map:
  - 0–5: GPR1–GPR6
  - 6–11: IS, SS, DS, IP, SP, DP
  - 12: `status_register`, zero-extended to 20 bits
  - 13: `instruction_count`
  - 14: `memory_access_count`
  - 15: `memory_correction_count`
  - 16–31: unmapped
- Unmapped address: that port's data is 0 and `rsp_error` = 1.
- FSM states are IDLE, CAPTURE and RESPOND.
  - IDLE: `req_ready` = 1. When `req_valid` is high, latch both addresses and go to CAPTURE.
  - CAPTURE: `req_ready` = 0. Sample both selected sources into the hold registers in this single cycle, compute `rsp_error` and `same_register_flag`, then go to RESPOND.
  - RESPOND: `rsp_valid` = 1. Data, error and flag stay stable until `rsp_ready` is high. On that cycle, return to IDLE.
- Because both ports sample in the same cycle, reading two counters returns values from the same clock edge.
- `same_register_flag` is computed on the raw 5-bit addresses, including unmapped addresses.
- Source values that change after CAPTURE do not affect the held response.

## Timing
- Request accepted at edge N → CAPTURE during N+1 → `rsp_valid` high from N+2.
- Minimum turnaround is 3 cycles per request. The earliest possible next accept is the cycle after the response handshake.
- `req_ready` and `rsp_valid` are registered state decodes and never both high.
- A request is dropped only if it is never presented while `req_ready` is high. `req_valid` while busy is ignored and must be held by the initiator.
- Reset at any state, including mid-RESPOND:
  - next state IDLE
  - `req_ready` = 1
  - `rsp_valid` = 0
  - `rsp_data_a` = `rsp_data_b` = 0
  - `rsp_error` = 0
  - `same_register_flag` = 0
  - latched addresses cleared to 0
  - any pending response is discarded
- All outputs take the reset values listed above.

## Structure
- Package `register_map_pkg` holds:
  - `DATA_WIDTH`, `ADDR_WIDTH`, `STATUS_WIDTH`
  - the address constants (`ADDR_GPR1`…`ADDR_MEM_CORR`, `ADDR_LAST_MAPPED` = 15)
  - the FSM state enum `rrp_state_t`
- Sub-module `register_read_mux` is combinational. It maps one address to a 20-bit value plus an `unmapped` bit, and is instantiated twice (ports A and B).

## Test plan
- **Reset values:** reset for 2 cycles, then release → `req_ready` = 1, `rsp_valid` = 0, all data and flags 0.
- **Two GPR reads:** GPR3 = 0x12345, DP = 0xABCDE; request a = 2, b = 11 → 2 cycles later `rsp_data_a` = 0x12345, `rsp_data_b` = 0xABCDE, error 0, flag 0.
- **Backpressure:** `rsp_ready` low for 5 cycles while GPR3 changes to 0 → response stays 0x12345. `req_ready` stays 0 until the cycle after `rsp_ready` = 1.
- **Coherent counter snapshot:** counters increment every cycle; read a = 13, b = 14 with both counters equal → returned values are equal. Same address (a = b = 13) → `same_register_flag` = 1.
- **Unmapped address and status extension:** a = 12 with `status_register` = 0x7FFF, b = 20 → `rsp_data_a` = 0x07FFF, `rsp_data_b` = 0, `rsp_error` = 1.
- **Reset mid-operation:** assert `reset` during RESPOND → next cycle `rsp_valid` = 0, data 0, `req_ready` = 1. A new request then completes normally.
